// File: rtl/planificador_pisos.sv
`default_nettype none
// =============================================================================
// planificador_pisos : collective (SCAN) elevator call scheduler
// Rev 1.0
// =============================================================================
module planificador_pisos #(
    parameter int N_PISOS  = 4,
    parameter int PISO_W   = 2,
    parameter int T_ESPERA = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PISOS-1:0] botones,
    input  logic               cambio_piso,
    input  logic               fin_servicio,
    output logic [N_PISOS-1:0] luces,
    output logic [PISO_W-1:0]  display,
    output logic [1:0]         motor,
    output logic               abrir,
    output logic               aviso
);

    localparam int TIMER_W = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;
    localparam logic [TIMER_W-1:0] c_timer_fin = TIMER_W'(T_ESPERA - 1);
    localparam logic [PISO_W-1:0]  c_piso_top  = PISO_W'(N_PISOS - 1);
    localparam logic [PISO_W-1:0]  c_piso_bajo = '0;
    localparam logic [1:0] c_motor_paro = 2'b00;
    localparam logic [1:0] c_motor_sube = 2'b01;
    localparam logic [1:0] c_motor_baja = 2'b10;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PARADA   = 2'd3
    } estado_t;

    estado_t             r_estado, w_estado_sig;
    logic [N_PISOS-1:0]  r_pend, w_pend_sig;
    logic [N_PISOS-1:0]  w_aqui, w_arriba, w_abajo, w_mascara, w_clr;
    logic [PISO_W-1:0]   r_piso, w_piso_sig;
    logic [TIMER_W-1:0]  r_timer, w_timer_sig;
    logic [1:0]          r_motor, w_motor_sig;
    logic                r_abrir, w_abrir_sig;
    logic                r_aviso, w_aviso_sig;
    logic                w_hay_aqui, w_hay_arriba, w_hay_abajo;

    always_comb begin
        w_aqui   = '0;
        w_arriba = '0;
        w_abajo  = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            w_aqui[i]   = (PISO_W'(i) == r_piso);
            w_arriba[i] = (PISO_W'(i) >  r_piso);
            w_abajo[i]  = (PISO_W'(i) <  r_piso);
        end
    end

    assign w_hay_aqui   = |(r_pend & w_aqui);
    assign w_hay_arriba = |(r_pend & w_arriba);
    assign w_hay_abajo  = |(r_pend & w_abajo);

    always_comb begin
        w_estado_sig = r_estado;
        w_piso_sig   = r_piso;
        w_abrir_sig  = 1'b0;
        w_timer_sig  = '0;
        w_aviso_sig  = r_aviso;
        w_motor_sig  = c_motor_paro;

        case (r_estado)
            REPOSO: begin
                if (w_hay_aqui) begin
                    w_estado_sig = PARADA;
                    w_abrir_sig  = 1'b1;
                end else if (w_hay_arriba) begin
                    w_estado_sig = SUBIENDO;
                end else if (w_hay_abajo) begin
                    w_estado_sig = BAJANDO;
                end
            end
            SUBIENDO: begin
                // Stopping takes precedence; a floor pulse in the stop cycle is dropped.
                if (w_hay_aqui) begin
                    w_estado_sig = PARADA;
                    w_abrir_sig  = 1'b1;
                end else if (w_hay_arriba) begin
                    if (cambio_piso && (r_piso != c_piso_top))
                        w_piso_sig = r_piso + 1'b1;
                end else begin
                    w_estado_sig = REPOSO;
                end
            end
            BAJANDO: begin
                if (w_hay_aqui) begin
                    w_estado_sig = PARADA;
                    w_abrir_sig  = 1'b1;
                end else if (w_hay_abajo) begin
                    if (cambio_piso && (r_piso != c_piso_bajo))
                        w_piso_sig = r_piso - 1'b1;
                end else begin
                    w_estado_sig = REPOSO;
                end
            end
            PARADA: begin
                if (fin_servicio) begin
                    w_estado_sig = REPOSO;
                    w_aviso_sig  = 1'b0;
                end else if (r_timer == c_timer_fin) begin
                    w_timer_sig  = r_timer;
                    w_aviso_sig  = 1'b1;
                end else begin
                    w_timer_sig  = r_timer + 1'b1;
                end
            end
            default: w_estado_sig = REPOSO;
        endcase

        case (w_estado_sig)
            SUBIENDO: w_motor_sig = c_motor_sube;
            BAJANDO:  w_motor_sig = c_motor_baja;
            default:  w_motor_sig = c_motor_paro;
        endcase

        // The served floor's button is ignored while its door cycle is in progress.
        w_mascara  = ((r_estado == PARADA) || w_abrir_sig) ? w_aqui : '0;
        w_clr      = w_abrir_sig ? w_aqui : '0;
        w_pend_sig = (r_pend | (botones & ~w_mascara)) & ~w_clr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= REPOSO;
            r_pend   <= '0;
            r_piso   <= '0;
            r_timer  <= '0;
            r_motor  <= c_motor_paro;
            r_abrir  <= 1'b0;
            r_aviso  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_pend   <= w_pend_sig;
            r_piso   <= w_piso_sig;
            r_timer  <= w_timer_sig;
            r_motor  <= w_motor_sig;
            r_abrir  <= w_abrir_sig;
            r_aviso  <= w_aviso_sig;
        end
    end

    assign luces   = r_pend;
    assign display = r_piso;
    assign motor   = r_motor;
    assign abrir   = r_abrir;
    assign aviso   = r_aviso;

endmodule
`default_nettype wire

// File: tb/tb_planificador_pisos.sv
`default_nettype none
// =============================================================================
// tb_planificador_pisos : directed vector bench for planificador_pisos
// Rev 1.0
// =============================================================================
module tb_planificador_pisos;

    localparam int N_PISOS  = 4;
    localparam int PISO_W   = 2;
    localparam int T_ESPERA = 200;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_PISOS-1:0] botones;
    logic               cambio_piso;
    logic               fin_servicio;
    logic [N_PISOS-1:0] luces;
    logic [PISO_W-1:0]  display;
    logic [1:0]         motor;
    logic               abrir;
    logic               aviso;

    always #5 clk = ~clk;

    planificador_pisos #(
        .N_PISOS  (N_PISOS),
        .PISO_W   (PISO_W),
        .T_ESPERA (T_ESPERA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .botones      (botones),
        .cambio_piso  (cambio_piso),
        .fin_servicio (fin_servicio),
        .luces        (luces),
        .display      (display),
        .motor        (motor),
        .abrir        (abrir),
        .aviso        (aviso)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] bot;
        logic       cp;
        logic       fin;
        logic [3:0] e_luces;
        logic [1:0] e_disp;
        logic [1:0] e_motor;
        logic       e_abrir;
        logic       e_aviso;
    } vec_t;

    vec_t tabla[$];
    int   aplicados = 0;
    int   fallos    = 0;

    task automatic add(input logic r, input logic [3:0] b, input logic cp, input logic f,
                       input logic [3:0] l, input logic [1:0] d, input logic [1:0] m,
                       input logic a, input logic w);
        vec_t v;
        v.rst_n = r; v.bot = b; v.cp = cp; v.fin = f;
        v.e_luces = l; v.e_disp = d; v.e_motor = m; v.e_abrir = a; v.e_aviso = w;
        tabla.push_back(v);
    endtask

    task automatic paso(input logic r, input logic [3:0] b, input logic cp, input logic f);
        reset = r; botones = b; cambio_piso = cp; fin_servicio = f;
        @(posedge clk);
        #1;
    endtask

    task automatic comprobar(input string nombre, input logic [3:0] l, input logic [1:0] d,
                             input logic [1:0] m, input logic a, input logic w);
        aplicados++;
        if ({luces, display, motor, abrir, aviso} !== {l, d, m, a, w}) begin
            fallos++;
            $display("FAIL %s: got luces=%b display=%0d motor=%b abrir=%b aviso=%b, expected luces=%b display=%0d motor=%b abrir=%b aviso=%b",
                     nombre, luces, display, motor, abrir, aviso, l, d, m, a, w);
        end
    endtask

    initial begin
        reset = 1'b0; botones = '0; cambio_piso = 1'b0; fin_servicio = 1'b0;

        // reset state
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        // call at the current floor: lamp, then door pulse, motor idle
        add(1, 4'b0001, 0, 0, 4'b0001, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 1, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 1, 4'b0000, 0, 2'b00, 0, 0);
        // floor 0 -> floor 2, third pulse arrives at the stop and is ignored
        add(1, 4'b0100, 0, 0, 4'b0100, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0100, 0, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0100, 1, 2'b01, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0100, 1, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0100, 2, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0000, 2, 2'b00, 1, 0);
        add(1, 4'b0000, 0, 1, 4'b0000, 2, 2'b00, 0, 0);
        // going up with calls at 3 and 0: serve 3, one idle cycle, then down to 0
        add(1, 4'b1000, 0, 0, 4'b1000, 2, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b1000, 2, 2'b01, 0, 0);
        add(1, 4'b0001, 0, 0, 4'b1001, 2, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b1001, 3, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0001, 3, 2'b00, 1, 0);
        add(1, 4'b0000, 0, 1, 4'b0001, 3, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0001, 3, 2'b10, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0001, 2, 2'b10, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0001, 1, 2'b10, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b0001, 0, 2'b10, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 1, 0);
        add(1, 4'b0000, 0, 1, 4'b0000, 0, 2'b00, 0, 0);
        // spurious pulses in REPOSO
        add(1, 4'b0000, 1, 0, 4'b0000, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 1, 4'b0000, 0, 2'b00, 0, 0);
        // held button at the served floor is masked during the door cycle
        add(1, 4'b0001, 0, 0, 4'b0001, 0, 2'b00, 0, 0);
        add(1, 4'b0001, 0, 0, 4'b0000, 0, 2'b00, 1, 0);
        add(1, 4'b0001, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 1, 4'b0000, 0, 2'b00, 0, 0);
        // reset while travelling up with pending 1010
        add(1, 4'b1010, 0, 0, 4'b1010, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b1010, 0, 2'b01, 0, 0);
        add(1, 4'b0000, 1, 0, 4'b1010, 1, 2'b01, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        // button at the new floor in the same cycle as the pulse
        add(1, 4'b1000, 0, 0, 4'b1000, 0, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b1000, 0, 2'b01, 0, 0);
        add(1, 4'b0010, 1, 0, 4'b1010, 1, 2'b01, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b1000, 1, 2'b00, 1, 0);
        add(1, 4'b0000, 0, 1, 4'b1000, 1, 2'b00, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b1000, 1, 2'b01, 0, 0);

        foreach (tabla[i]) begin
            paso(tabla[i].rst_n, tabla[i].bot, tabla[i].cp, tabla[i].fin);
            comprobar($sformatf("vec%0d", i), tabla[i].e_luces, tabla[i].e_disp,
                      tabla[i].e_motor, tabla[i].e_abrir, tabla[i].e_aviso);
        end

        // door-cycle timeout: aviso rises T_ESPERA cycles after entering PARADA
        paso(0, 4'b0000, 0, 0);
        comprobar("to_reset", 4'b0000, 0, 2'b00, 0, 0);
        paso(1, 4'b0001, 0, 0);
        comprobar("to_call", 4'b0001, 0, 2'b00, 0, 0);
        paso(1, 4'b0000, 0, 0);
        comprobar("to_open", 4'b0000, 0, 2'b00, 1, 0);
        for (int k = 1; k < T_ESPERA; k++) paso(1, 4'b0000, 0, 0);
        comprobar("to_before", 4'b0000, 0, 2'b00, 0, 0);
        paso(1, 4'b0000, 0, 0);
        comprobar("to_aviso", 4'b0000, 0, 2'b00, 0, 1);
        for (int k = 0; k < 5; k++) paso(1, 4'b0000, 1, 0);
        comprobar("to_held", 4'b0000, 0, 2'b00, 0, 1);
        paso(1, 4'b0000, 0, 1);
        comprobar("to_clear", 4'b0000, 0, 2'b00, 0, 0);
        paso(1, 4'b0100, 0, 0);
        comprobar("to_newcall", 4'b0100, 0, 2'b00, 0, 0);
        paso(1, 4'b0000, 0, 0);
        comprobar("to_reposo", 4'b0100, 0, 2'b01, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", aplicados, fallos);
        $finish;
    end

endmodule
`default_nettype wire
